// File: rtl/osd_window_arbiter_if.sv
// ---------------------------------------------------------------------------
// osd_window_arbiter_if
// Host configuration bus of the OSD window arbiter.
//   cfg_wr_en   host -> arbiter  write strobe, taken only while cfg_ready=1
//   cfg_addr    host -> arbiter  [3:2] window select, [1:0] register select
//   cfg_wdata   host -> arbiter  24-bit write data
//   cfg_ready   arbiter -> host  write accept (low only in a commit cycle)
//   cfg_applied arbiter -> host  one-cycle pulse after pending config commits
// ---------------------------------------------------------------------------
interface osd_window_arbiter_if;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic        cfg_ready;
    logic        cfg_applied;

    modport master (
        output cfg_wr_en,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready,
        input  cfg_applied
    );

    modport slave (
        input  cfg_wr_en,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready,
        output cfg_applied
    );
endinterface

// File: rtl/osd_window_arbiter.sv
// ---------------------------------------------------------------------------
// osd_window_arbiter
// On-screen-display window scheduler for the HDMI output path. Four
// rectangular windows; for each active pixel the lowest-index window that
// covers it replaces the video colour. Host writes land in a pending bank
// and are copied to the active bank on a rising edge of i_vs, so a frame
// never sees a half-updated window.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   cfg                 host configuration bus (slave side)
//   i_hs/i_vs/i_de      input syncs and data enable
//   i_data              input RGB888 pixel
//   i_x/i_y             position of the current pixel
//   o_hs/o_vs/o_de      syncs and data enable delayed by 2 cycles
//   o_data              pixel after window substitution
//   o_win_hit           one-hot grant, 0 when no window owns the pixel
//   o_win_id            index of the granted window, 0 when none
// ---------------------------------------------------------------------------
module osd_window_arbiter #(
    parameter int NUM_WIN = 4,
    parameter int COORD_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    osd_window_arbiter_if.slave  cfg,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_de,
    input  logic [23:0]          i_data,
    input  logic [COORD_W-1:0]   i_x,
    input  logic [COORD_W-1:0]   i_y,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic                 o_de,
    output logic [23:0]          o_data,
    output logic [NUM_WIN-1:0]   o_win_hit,
    output logic [1:0]           o_win_id
);

    logic [COORD_W-1:0] r_pendXStart [NUM_WIN];
    logic [COORD_W-1:0] r_pendXEnd   [NUM_WIN];
    logic [COORD_W-1:0] r_pendYStart [NUM_WIN];
    logic [COORD_W-1:0] r_pendYEnd   [NUM_WIN];
    logic [23:0]        r_pendColour [NUM_WIN];
    logic [NUM_WIN-1:0] r_pendEn;

    logic [COORD_W-1:0] r_actXStart [NUM_WIN];
    logic [COORD_W-1:0] r_actXEnd   [NUM_WIN];
    logic [COORD_W-1:0] r_actYStart [NUM_WIN];
    logic [COORD_W-1:0] r_actYEnd   [NUM_WIN];
    logic [23:0]        r_actColour [NUM_WIN];
    logic [NUM_WIN-1:0] r_actEn;

    logic               r_dirty;
    logic               r_vsPrev;
    logic               r_cfgApplied;

    logic [NUM_WIN-1:0] r_s1Hit;
    logic               r_s1Hs;
    logic               r_s1Vs;
    logic               r_s1De;
    logic [23:0]        r_s1Data;

    logic               w_vsRise;
    logic               w_commit;
    logic               w_wrAccept;
    logic [1:0]         w_wrWin;
    logic [1:0]         w_wrReg;
    logic [NUM_WIN-1:0] w_hit;
    logic [NUM_WIN-1:0] w_grant;
    logic [1:0]         w_grantId;
    logic [23:0]        w_grantData;

    // A commit blocks the host for exactly one cycle so the pending bank is
    // copied in a consistent state; the colliding write must be retried.
    assign w_vsRise        = i_vs & ~r_vsPrev;
    assign w_commit        = w_vsRise & r_dirty;
    assign w_wrAccept      = cfg.cfg_wr_en & ~w_commit;
    assign w_wrWin         = cfg.cfg_addr[3:2];
    assign w_wrReg         = cfg.cfg_addr[1:0];
    assign cfg.cfg_ready   = ~w_commit;
    assign cfg.cfg_applied = r_cfgApplied;

    // Pending bank: host writes only, never seen by the hit logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                r_pendXStart[w] <= '0;
                r_pendXEnd[w]   <= '0;
                r_pendYStart[w] <= '0;
                r_pendYEnd[w]   <= '0;
                r_pendColour[w] <= '0;
            end
            r_pendEn <= '0;
        end else if (w_wrAccept) begin
            case (w_wrReg)
                2'd0: begin
                    r_pendXStart[w_wrWin] <= COORD_W'(cfg.cfg_wdata[11:0]);
                    r_pendXEnd[w_wrWin]   <= COORD_W'(cfg.cfg_wdata[23:12]);
                end
                2'd1: begin
                    r_pendYStart[w_wrWin] <= COORD_W'(cfg.cfg_wdata[11:0]);
                    r_pendYEnd[w_wrWin]   <= COORD_W'(cfg.cfg_wdata[23:12]);
                end
                2'd2: r_pendColour[w_wrWin] <= cfg.cfg_wdata;
                default: r_pendEn[w_wrWin] <= cfg.cfg_wdata[0];
            endcase
        end
    end

    // Active bank: whole pending bank copied at a vsync rise with dirty set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                r_actXStart[w] <= '0;
                r_actXEnd[w]   <= '0;
                r_actYStart[w] <= '0;
                r_actYEnd[w]   <= '0;
                r_actColour[w] <= '0;
            end
            r_actEn <= '0;
        end else if (w_commit) begin
            r_actXStart <= r_pendXStart;
            r_actXEnd   <= r_pendXEnd;
            r_actYStart <= r_pendYStart;
            r_actYEnd   <= r_pendYEnd;
            r_actColour <= r_pendColour;
            r_actEn     <= r_pendEn;
        end
    end

    // Dirty flag, vsync edge detector and the commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty      <= 1'b0;
            r_vsPrev     <= 1'b0;
            r_cfgApplied <= 1'b0;
        end else begin
            r_vsPrev     <= i_vs;
            r_cfgApplied <= w_commit;
            if (w_commit) begin
                r_dirty <= 1'b0;
            end else if (w_wrAccept) begin
                r_dirty <= 1'b1;
            end
        end
    end

    // Inclusive unsigned bounds; start > end on either axis can never match.
    always_comb begin
        w_hit = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            w_hit[w] = r_actEn[w] & i_de
                     & (i_x >= r_actXStart[w]) & (i_x <= r_actXEnd[w])
                     & (i_y >= r_actYStart[w]) & (i_y <= r_actYEnd[w]);
        end
    end

    // Stage 1: hit vector plus the video it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Hit  <= '0;
            r_s1Hs   <= 1'b0;
            r_s1Vs   <= 1'b0;
            r_s1De   <= 1'b0;
            r_s1Data <= '0;
        end else begin
            r_s1Hit  <= w_hit;
            r_s1Hs   <= i_hs;
            r_s1Vs   <= i_vs;
            r_s1De   <= i_de;
            r_s1Data <= i_data;
        end
    end

    // Fixed priority: walking downwards lets the lowest hit index win.
    always_comb begin
        w_grant     = '0;
        w_grantId   = 2'd0;
        w_grantData = r_s1Data;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if (r_s1Hit[w]) begin
                w_grant     = '0;
                w_grant[w]  = 1'b1;
                w_grantId   = 2'(w);
                w_grantData = r_actColour[w];
            end
        end
    end

    // Stage 2: arbitration result and substituted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
            o_de      <= 1'b0;
            o_data    <= '0;
            o_win_hit <= '0;
            o_win_id  <= 2'd0;
        end else begin
            o_hs      <= r_s1Hs;
            o_vs      <= r_s1Vs;
            o_de      <= r_s1De;
            o_data    <= w_grantData;
            o_win_hit <= w_grant;
            o_win_id  <= w_grantId;
        end
    end

endmodule
